// File: rtl/hyperbus_w2phy_if.sv
// Handshake bundle between the AXI W / AW-AR side, the
// write serializer and the Hyperbus PHY transmit FIFO.
interface hyperbus_w2phy_if #(
  parameter int AxiDataWidth = 64,
  parameter int NumPhys      = 2,
  parameter int AddrWidth    = $clog2(AxiDataWidth/8)
);
  logic                      trans_handshake_i;
  logic                      is_a_write_i;
  logic [2:0]                size_i;
  logic [AddrWidth-1:0]      start_addr_i;
  logic [7:0]                burst_len_i;
  logic                      axi_valid_i;
  logic                      axi_ready_o;
  logic [AxiDataWidth-1:0]   axi_data_i;
  logic [AxiDataWidth/8-1:0] axi_strb_i;
  logic                      axi_last_i;
  logic                      phy_valid_o;
  logic                      phy_ready_i;
  logic [16*NumPhys-1:0]     phy_data_o;
  logic [2*NumPhys-1:0]      phy_strb_o;
  logic                      phy_last_o;
  logic                      last_err_o;

  modport slave (
    input  trans_handshake_i, is_a_write_i, size_i,
    input  start_addr_i, burst_len_i,
    input  axi_valid_i, axi_data_i, axi_strb_i, axi_last_i,
    input  phy_ready_i,
    output axi_ready_o, phy_valid_o, phy_data_o,
    output phy_strb_o, phy_last_o, last_err_o
  );

  modport master (
    output trans_handshake_i, is_a_write_i, size_i,
    output start_addr_i, burst_len_i,
    output axi_valid_i, axi_data_i, axi_strb_i, axi_last_i,
    output phy_ready_i,
    input  axi_ready_o, phy_valid_o, phy_data_o,
    input  phy_strb_o, phy_last_o, last_err_o
  );
endinterface

// File: rtl/hyperbus_w2phy.sv
// AXI W beat to Hyperbus PHY word serializer with narrow-transfer masking.
// Optional: HYPERBUS_W2PHY_SKIP_EMPTY_EN skips non-final all-zero-strobe words.
module hyperbus_w2phy #(
  parameter int AxiDataWidth = 64,
  parameter int NumPhys      = 2,
  parameter int AddrWidth    = $clog2(AxiDataWidth/8)
) (
  input logic            clk_i,
  input logic            rst_ni,
  hyperbus_w2phy_if.slave bus
);
  localparam int Pb   = 2*NumPhys;
  localparam int Pw   = 16*NumPhys;
  localparam int Nab  = AxiDataWidth/8;
  localparam int Wpb  = Nab/Pb;
  localparam int IdxW = (Wpb > 1) ? $clog2(Wpb) : 1;
  localparam int PbW  = $clog2(Pb);

  typedef enum logic [1:0] {Idle, WaitAxi, Send} state_e;

  state_e                  state_q, state_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [2:0]              size_q, size_d;
  logic [7:0]              beats_q, beats_d;
  logic [AxiDataWidth-1:0] data_q, data_d;
  logic [Nab-1:0]          strb_q, strb_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [IdxW-1:0]         last_idx_q, last_idx_d;
  logic [AddrWidth-1:0]    lo_q, lo_d;
  logic [AddrWidth-1:0]    hi_q, hi_d;
  logic                    final_q, final_d;
  logic                    axi_ready_q, axi_ready_d;
  logic                    phy_valid_q, phy_valid_d;
  logic [Pw-1:0]           phy_data_q, phy_data_d;
  logic [Pb-1:0]           phy_strb_q, phy_strb_d;
  logic                    phy_last_q, phy_last_d;
  logic                    last_err_q, last_err_d;

  logic [AddrWidth-1:0]    sz_mask;
  logic [AddrWidth-1:0]    hi_a;
  logic [Pb-1:0]           win;
  logic [Pb-1:0]           wstrb;
  logic                    load;
  logic                    adv;

  always_comb begin
    for (int i = 0; i < AddrWidth; i++) begin
      sz_mask[i] = (i < int'(size_q));
    end
    hi_a = (addr_q & ~sz_mask) + sz_mask;

    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    beats_d     = beats_q;
    data_d      = data_q;
    strb_d      = strb_q;
    idx_d       = idx_q;
    last_idx_d  = last_idx_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    final_d     = final_q;
    axi_ready_d = axi_ready_q;
    phy_valid_d = phy_valid_q;
    phy_data_d  = phy_data_q;
    phy_strb_d  = phy_strb_q;
    phy_last_d  = phy_last_q;
    last_err_d  = 1'b0;
    load        = 1'b0;
    adv         = 1'b0;

    unique case (state_q)
      Idle: begin
        if (bus.trans_handshake_i && bus.is_a_write_i) begin
          addr_d      = bus.start_addr_i;
          size_d      = bus.size_i;
          beats_d     = bus.burst_len_i;
          state_d     = WaitAxi;
          axi_ready_d = 1'b1;
        end
      end
      WaitAxi: begin
        if (bus.axi_valid_i) begin
          data_d      = bus.axi_data_i;
          strb_d      = bus.axi_strb_i;
          lo_d        = addr_q;
          hi_d        = hi_a;
          idx_d       = IdxW'(addr_q >> PbW);
          last_idx_d  = IdxW'(hi_a >> PbW);
          final_d     = (beats_q == 8'd0);
          last_err_d  = (bus.axi_last_i != final_d);
          axi_ready_d = 1'b0;
          state_d     = Send;
          load        = 1'b1;
        end
      end
      Send: begin
        // A dropped (skipped) word advances without waiting on the PHY
        adv = phy_valid_q ? bus.phy_ready_i : 1'b1;
        if (adv) begin
          if (idx_q != last_idx_q) begin
            idx_d = idx_q + IdxW'(1);
            load  = 1'b1;
          end else begin
            addr_d      = hi_a + AddrWidth'(1);
            beats_d     = beats_q - 8'd1;
            phy_valid_d = 1'b0;
            phy_last_d  = 1'b0;
            state_d     = final_q ? Idle : WaitAxi;
            axi_ready_d = !final_q;
          end
        end
      end
      default: state_d = Idle;
    endcase

    for (int j = 0; j < Pb; j++) begin
      win[j] = (int'(idx_d)*Pb + j >= int'(lo_d)) &&
               (int'(idx_d)*Pb + j <= int'(hi_d));
    end
    wstrb = strb_d[int'(idx_d)*Pb +: Pb] & win;

    if (load) begin
      phy_data_d  = data_d[int'(idx_d)*Pw +: Pw];
      phy_strb_d  = wstrb;
      phy_last_d  = final_d && (idx_d == last_idx_d);
      phy_valid_d = 1'b1;
`ifdef HYPERBUS_W2PHY_SKIP_EMPTY_EN
      if (wstrb == '0 && !phy_last_d) phy_valid_d = 1'b0;
`else
      phy_valid_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      addr_q      <= '0;
      size_q      <= '0;
      beats_q     <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      final_q     <= 1'b0;
      axi_ready_q <= 1'b0;
      phy_valid_q <= 1'b0;
      phy_data_q  <= '0;
      phy_strb_q  <= '0;
      phy_last_q  <= 1'b0;
      last_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      beats_q     <= beats_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      final_q     <= final_d;
      axi_ready_q <= axi_ready_d;
      phy_valid_q <= phy_valid_d;
      phy_data_q  <= phy_data_d;
      phy_strb_q  <= phy_strb_d;
      phy_last_q  <= phy_last_d;
      last_err_q  <= last_err_d;
    end
  end

  assign bus.axi_ready_o = axi_ready_q;
  assign bus.phy_valid_o = phy_valid_q;
  assign bus.phy_data_o  = phy_data_q;
  assign bus.phy_strb_o  = phy_strb_q;
  assign bus.phy_last_o  = phy_last_q;
  assign bus.last_err_o  = last_err_q;

endmodule
